// File: rtl/wb_regfile.sv
// Write-back stage register file: 32x64 with byte-lane writes and a write counter.
// Optional WB_REGFILE_BYPASS_EN forwards a pending write onto the read ports.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] wb_alu_out,
    input  logic [63:0] wb_mem_out,
    input  logic [4:0]  wb_rd,
    input  logic [1:0]  wb_ctrl,
    input  logic [7:0]  wb_ppp,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [63:0] rs_data,
    output logic [63:0] rt_data,
    output logic [15:0] wr_busy_cnt
);

    logic [63:0] regs [32];
    logic [63:0] wdata;
    logic [63:0] mask;
    logic        we;
    logic        commit;

    assign wdata  = wb_ctrl[0] ? wb_mem_out : wb_alu_out;
    assign we     = wb_ctrl[1] && (wb_rd != 5'd0);
    assign commit = we && (wb_ppp != 8'h00);

    always_comb begin
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[8*i +: 8] = {8{wb_ppp[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_rd] <= (regs[wb_rd] & ~mask) | (wdata & mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_busy_cnt <= '0;
        end else if (commit && (wr_busy_cnt != 16'hFFFF)) begin
            wr_busy_cnt <= wr_busy_cnt + 16'd1;
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != 5'd0) begin
            rs_data = regs[rs_addr];
            if (we && (rs_addr == wb_rd)) begin
                rs_data = (regs[rs_addr] & ~mask) | (wdata & mask);
            end
        end
        if (rt_addr != 5'd0) begin
            rt_data = regs[rt_addr];
            if (we && (rt_addr == wb_rd)) begin
                rt_data = (regs[rt_addr] & ~mask) | (wdata & mask);
            end
        end
    end
`else
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != 5'd0) begin
            rs_data = regs[rs_addr];
        end
        if (rt_addr != 5'd0) begin
            rt_data = regs[rt_addr];
        end
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
// Bypass expectations follow WB_REGFILE_BYPASS_EN.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] wb_alu_out;
    logic [63:0] wb_mem_out;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_ctrl;
    logic [7:0]  wb_ppp;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [63:0] rs_data;
    logic [63:0] rt_data;
    logic [15:0] wr_busy_cnt;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk(clk),
        .rst(rst),
        .wb_alu_out(wb_alu_out),
        .wb_mem_out(wb_mem_out),
        .wb_rd(wb_rd),
        .wb_ctrl(wb_ctrl),
        .wb_ppp(wb_ppp),
        .rs_addr(rs_addr),
        .rt_addr(rt_addr),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .wr_busy_cnt(wr_busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic write(input logic [4:0] rd, input logic [1:0] ctrl,
                         input logic [63:0] alu, input logic [63:0] mem,
                         input logic [7:0] ppp);
        @(negedge clk);
        wb_rd = rd;
        wb_ctrl = ctrl;
        wb_alu_out = alu;
        wb_mem_out = mem;
        wb_ppp = ppp;
        @(posedge clk);
        #1;
        wb_ctrl = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            checks++;
            if (rs_data !== 64'h0 || rt_data !== 64'h0) begin
                errors++;
                $display("FAIL reset_read idx %0d rs %h rt %h want 0",
                         i, rs_data, rt_data);
            end
        end
        checks++;
        if (wr_busy_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h want 0", wr_busy_cnt);
        end
    endtask

    task automatic test_byte_mask;
        write(5, 2'b10, 64'h0123_4567_89AB_CDEF, 64'h0, 8'hFF);
        write(5, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h0F);
        rs_addr = 5;
        rt_addr = 5;
        #1;
        checks++;
        if (rs_data !== 64'h0123_4567_FFFF_FFFF) begin
            errors++;
            $display("FAIL byte_mask rs %h want 0123_4567_ffff_ffff", rs_data);
        end
        checks++;
        if (rt_data !== 64'h0123_4567_FFFF_FFFF) begin
            errors++;
            $display("FAIL same_addr rt %h want 0123_4567_ffff_ffff", rt_data);
        end
        checks++;
        if (wr_busy_cnt !== 16'd2) begin
            errors++;
            $display("FAIL byte_mask_cnt got %0d want 2", wr_busy_cnt);
        end
    endtask

    task automatic test_reg0;
        write(0, 2'b10, 64'hDEAD, 64'hDEAD, 8'hFF);
        rs_addr = 0;
        #1;
        checks++;
        if (rs_data !== 64'h0) begin
            errors++;
            $display("FAIL reg0_read got %h want 0", rs_data);
        end
        checks++;
        if (wr_busy_cnt !== 16'd2) begin
            errors++;
            $display("FAIL reg0_cnt got %0d want 2", wr_busy_cnt);
        end
    endtask

    task automatic test_mem_select;
        write(7, 2'b11, 64'h5555, 64'hAAAA, 8'hFF);
        write(8, 2'b10, 64'h5555, 64'hAAAA, 8'hFF);
        rs_addr = 7;
        rt_addr = 8;
        #1;
        checks++;
        if (rs_data !== 64'hAAAA) begin
            errors++;
            $display("FAIL mem_sel got %h want aaaa", rs_data);
        end
        checks++;
        if (rt_data !== 64'h5555) begin
            errors++;
            $display("FAIL alu_sel got %h want 5555", rt_data);
        end
        checks++;
        if (wr_busy_cnt !== 16'd4) begin
            errors++;
            $display("FAIL sel_cnt got %0d want 4", wr_busy_cnt);
        end
    endtask

    task automatic test_noop;
        write(7, 2'b10, 64'h1234, 64'h0, 8'h00);
        write(7, 2'b01, 64'h9999, 64'h7777, 8'hFF);
        rs_addr = 7;
        #1;
        checks++;
        if (rs_data !== 64'hAAAA) begin
            errors++;
            $display("FAIL noop_data got %h want aaaa", rs_data);
        end
        checks++;
        if (wr_busy_cnt !== 16'd4) begin
            errors++;
            $display("FAIL noop_cnt got %0d want 4", wr_busy_cnt);
        end
    endtask

    task automatic test_bypass;
        logic [63:0] exp_pre;
`ifdef WB_REGFILE_BYPASS_EN
        exp_pre = 64'h1111_2222_0000_0000;
`else
        exp_pre = 64'h0;
`endif
        @(negedge clk);
        wb_rd = 9;
        wb_ctrl = 2'b10;
        wb_alu_out = 64'h1111_2222_3333_4444;
        wb_ppp = 8'hF0;
        rs_addr = 9;
        rt_addr = 8;
        #1;
        checks++;
        if (rs_data !== exp_pre) begin
            errors++;
            $display("FAIL bypass_pre got %h want %h", rs_data, exp_pre);
        end
        checks++;
        if (rt_data !== 64'h5555) begin
            errors++;
            $display("FAIL bypass_other got %h want 5555", rt_data);
        end
        @(posedge clk);
        #1;
        wb_ctrl = 2'b00;
        checks++;
        if (rs_data !== 64'h1111_2222_0000_0000) begin
            errors++;
            $display("FAIL bypass_post got %h want 1111_2222_0000_0000",
                     rs_data);
        end
    endtask

    task automatic test_reset_priority;
        @(negedge clk);
        rst = 1'b1;
        wb_rd = 3;
        wb_ctrl = 2'b10;
        wb_alu_out = 64'hCAFE;
        wb_ppp = 8'hFF;
        @(posedge clk);
        #1;
        wb_ctrl = 2'b00;
        rs_addr = 3;
        rt_addr = 5;
        #1;
        checks++;
        if (rs_data !== 64'h0 || rt_data !== 64'h0) begin
            errors++;
            $display("FAIL rst_prio rs %h rt %h want 0", rs_data, rt_data);
        end
        checks++;
        if (wr_busy_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_prio_cnt got %0d want 0", wr_busy_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        wb_rd = 4;
        wb_ctrl = 2'b10;
        wb_alu_out = 64'hBEEF;
        @(posedge clk);
        #1;
        wb_ctrl = 2'b00;
        rs_addr = 4;
        #1;
        checks++;
        if (rs_data !== 64'hBEEF) begin
            errors++;
            $display("FAIL first_write got %h want beef", rs_data);
        end
        checks++;
        if (wr_busy_cnt !== 16'd1) begin
            errors++;
            $display("FAIL first_write_cnt got %0d want 1", wr_busy_cnt);
        end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        wb_rd = 1;
        wb_ctrl = 2'b10;
        wb_alu_out = 64'h1;
        wb_ppp = 8'h01;
        repeat (65533) @(posedge clk);
        #1;
        checks++;
        if (wr_busy_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre got %h want fffe", wr_busy_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_busy_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach got %h want ffff", wr_busy_cnt);
        end
        repeat (3) @(posedge clk);
        #1;
        wb_ctrl = 2'b00;
        checks++;
        if (wr_busy_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got %h want ffff", wr_busy_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_alu_out = '0;
        wb_mem_out = '0;
        wb_rd = '0;
        wb_ctrl = '0;
        wb_ppp = '0;
        rs_addr = '0;
        rt_addr = '0;
        test_reset;
        test_byte_mask;
        test_reg0;
        test_mem_select;
        test_noop;
        test_bypass;
        test_reset_priority;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning): clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 wb_alu_out  in  64  ALU result from the EX/WB pipeline register.
REQ-003 wb_mem_out  in  64  load data from data memory, aligned to the same cycle as wb_alu_out.
REQ-004 wb_rd  in  5  destination register index.
REQ-005 wb_ctrl  in  2  bit1 = register write enable; bit0 = result select (1 = wb_mem_out, 0 = wb_alu_out).
REQ-006 wb_ppp  in  8  byte-lane write mask; bit i enables byte i, bits [8i+7:8i].
REQ-007 rs_addr, rt_addr  in  5 each  read-port indices from the ID stage.
REQ-008 rs_data, rt_data  out  64 each  read-port data, combinational from the addresses.
REQ-009 wr_busy_cnt  out  16  count of committed writes since reset, saturating.

Function
REQ-010 Storage SHALL be 32 x 64-bit registers; index 0 SHALL always read 0, and writes to index 0 SHALL be discarded (they are not counted).
REQ-011 Write data SHALL be wb_mem_out when wb_ctrl[0]=1, else wb_alu_out.
REQ-012 On a rising clk with rst=0, wb_ctrl[1]=1, wb_rd!=0: for each i with wb_ppp[i]=1, byte i of reg[wb_rd] SHALL take byte i of the write data; bytes with wb_ppp[i]=0 SHALL hold their value.
REQ-013 A write with wb_ctrl[1]=1 and wb_ppp=8'h00 SHALL leave the register unchanged and SHALL NOT increment wr_busy_cnt.
REQ-014 Write latency: the new value SHALL be visible in storage one clk edge after the write is presented.
REQ-015 Reads SHALL be combinational: rs_data = reg[rs_addr] and rt_data = reg[rt_addr], subject to REQ-010 and the Configuration section.
REQ-016 Both read ports SHALL be independent; rs_addr==rt_addr SHALL return identical data on both ports.
REQ-017 wr_busy_cnt SHALL increment by 1 on each committed write (REQ-012 condition with wb_ppp!=0); at 16'hFFFF it SHALL hold.
REQ-018 wb_ctrl[1]=0 SHALL be a no-op regardless of wb_rd, wb_ppp, and the data inputs.

Reset
REQ-019 While rst=1 at a clk edge, all 32 registers SHALL clear to 64'h0 and wr_busy_cnt SHALL clear to 0.
REQ-020 rst SHALL take priority over a simultaneous write; the write SHALL be lost.
REQ-021 After reset deasserts, the first write SHALL commit on the first clk edge with rst=0.

Configuration
REQ-022 Macro WB_REGFILE_BYPASS_EN SHALL select same-cycle write-to-read bypass.
REQ-023 With WB_REGFILE_BYPASS_EN defined: when a write is pending (wb_ctrl[1]=1, wb_rd!=0) and a read address equals wb_rd, that read port SHALL return the merged value: enabled bytes from the write data, other bytes from storage.
REQ-024 Without WB_REGFILE_BYPASS_EN: read ports SHALL return storage contents only; the pending write is visible from the next cycle.

Verification
REQ-025 Reset then read all 32 indices -> every rs_data and rt_data = 64'h0; wr_busy_cnt = 0.
REQ-026 Write reg5 = 64'h0123_4567_89AB_CDEF with ppp=8'hFF, ctrl=2'b10; then write reg5 alu_out = 64'hFFFF_FFFF_FFFF_FFFF with ppp=8'h0F -> rs_addr=5 reads 64'h0123_4567_FFFF_FFFF; wr_busy_cnt = 2.
REQ-027 Write reg0 with ppp=8'hFF and data 64'hDEAD -> rs_addr=0 reads 0; wr_busy_cnt unchanged.
REQ-028 ctrl=2'b11, mem_out=64'hAAAA, alu_out=64'h5555, rd=7, ppp=8'hFF -> reg7 = 64'hAAAA.
REQ-029 Preload reg9 = 64'h0; present write rd=9, data 64'h1111_2222_3333_4444, ppp=8'hF0, rs_addr=9 in the same cycle -> with the macro defined rs_data = 64'h1111_2222_0000_0000 before the edge; without the macro rs_data = 0 before the edge and 64'h1111_2222_0000_0000 after it.
REQ-030 Assert rst in the same cycle as a write to reg3 -> reg3 = 0 and wr_busy_cnt = 0 after the edge.
